// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-path types: word width, canonical NOP, queue entry and fetch FSM states.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StFault = 2'd1,
        StHalt  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: IMEM address/data, execute redirect, and the decode-facing valid/ready port.
interface if_fetch_unit_if;
    import rv32i_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_inst;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            out_fault;

    modport master (
        output imem_addr, out_valid, out_pc, out_inst, out_fault,
        input  imem_inst, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_pc, out_inst, out_fault,
        output imem_inst, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; flush empties it and wins over a same-cycle push.
module fetch_queue
    import rv32i_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  fetch_entry_t    wdata,
    output fetch_entry_t    head,
    output logic            valid,
    output logic [CntW-1:0] count
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_d = count_q + CntW'(1);
            else if (pop && !push) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    // Empty queue presents zeros so decode never sees stale storage.
    assign valid = (count_q != '0);
    assign head  = valid ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && (count_q == CntW'(Depth))));
    no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && !valid));

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch front end: owns the PC, fills the fetch queue, handles redirects.
module if_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned     QUEUE_DEPTH = 2
) (
    input logic             clk,
    input logic             rst,
    if_fetch_unit_if.master bus
);

    localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            push, pop, flush, can_push;
    logic            head_valid;
    logic [CntW-1:0] count;
    fetch_entry_t    wdata, head;

    assign pop      = head_valid && bus.out_ready;
    assign can_push = (count < CntW'(QUEUE_DEPTH)) || pop;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        wdata   = '{pc: pc_q, inst: bus.imem_inst, fault: 1'b0};
        if (bus.redirect_valid) begin
            // A head popped this cycle is still consumed; flush drops the rest.
            flush   = 1'b1;
            pc_d    = bus.redirect_pc;
            state_d = (bus.redirect_pc[1:0] == 2'b00) ? StRun : StFault;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (can_push) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
                StFault: begin
                    if (can_push) begin
                        push    = 1'b1;
                        wdata   = '{pc: pc_q, inst: NOP_INST, fault: 1'b1};
                        state_d = StHalt;
                    end
                end
                StHalt: ;
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue #(
        .Depth(QUEUE_DEPTH)
    ) u_queue (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(flush),
        .wdata(wdata),
        .head (head),
        .valid(head_valid),
        .count(count)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = head_valid;
    assign bus.out_pc    = head.pc;
    assign bus.out_inst  = head.inst;
    assign bus.out_fault = head.fault;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed plus randomized bench for if_fetch_unit against a queue-based behavioural model.
module tb_if_fetch_unit;
    import rv32i_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC   (RPC),
        .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign bus.imem_inst = inst_of(bus.imem_addr);

    // Behavioural model: expected queue contents, next fetch address, fault/halt flags.
    fetch_entry_t mq[$];
    logic [31:0]  mpc;
    bit           fault_pending;
    bit           halted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit popped;
        bit room;
        popped = (mq.size() != 0) && bus.out_ready;
        if (rst) begin
            mq.delete();
            mpc           = RPC;
            fault_pending = 0;
            halted        = 0;
        end else if (bus.redirect_valid) begin
            mq.delete();
            mpc           = bus.redirect_pc;
            fault_pending = (bus.redirect_pc[1:0] != 2'b00);
            halted        = 0;
        end else begin
            room = (mq.size() < DEPTH) || popped;
            if (popped) void'(mq.pop_front());
            if (!halted && room) begin
                if (fault_pending) begin
                    mq.push_back('{pc: mpc, inst: NOP_INST, fault: 1'b1});
                    fault_pending = 0;
                    halted        = 1;
                end else begin
                    mq.push_back('{pc: mpc, inst: inst_of(mpc), fault: 1'b0});
                    mpc = mpc + 32'd4;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
        chk({tag, ".addr"}, bus.imem_addr, mpc);
        if (mq.size() != 0) begin
            chk({tag, ".pc"}, bus.out_pc, mq[0].pc);
            chk({tag, ".inst"}, bus.out_inst, mq[0].inst);
            chk({tag, ".fault"}, {31'd0, bus.out_fault}, {31'd0, mq[0].fault});
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick("rst");
        tick("rst");
        rst = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset state
        do_reset();
        chk("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset.out_pc", bus.out_pc, 32'd0);
        chk("reset.out_inst", bus.out_inst, 32'd0);
        chk("reset.out_fault", {31'd0, bus.out_fault}, 32'd0);
        chk("reset.imem_addr", bus.imem_addr, RPC);

        // Streaming after reset release
        tick("stream");
        chk("stream.first_pc", bus.out_pc, 32'h0);
        chk("stream.first_valid", {31'd0, bus.out_valid}, 32'd1);
        tick("stream");
        chk("stream.second_pc", bus.out_pc, 32'h4);
        tick("stream");
        chk("stream.third_pc", bus.out_pc, 32'h8);
        for (int i = 0; i < 5; i++) tick("stream");

        // Backpressure from reset
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick("bp");
        chk("bp.addr_hold", bus.imem_addr, 32'h8);
        chk("bp.head_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        tick("bp_drain");
        chk("bp.drain1", bus.out_pc, 32'h4);
        tick("bp_drain");
        chk("bp.drain2", bus.out_pc, 32'h8);
        tick("bp_drain");
        chk("bp.drain3", bus.out_pc, 32'hC);

        // Redirect while full
        bus.out_ready = 1'b0;
        tick("fill");
        tick("fill");
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick("redir");
        bus.redirect_valid = 1'b0;
        chk("redir.empty", {31'd0, bus.out_valid}, 32'd0);
        chk("redir.addr", bus.imem_addr, 32'h100);
        tick("redir");
        chk("redir.pc", bus.out_pc, 32'h100);
        chk("redir.inst", bus.out_inst, inst_of(32'h100));

        // Redirect with simultaneous pop on a full queue
        tick("fill2");
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick("redir_pop");
        bus.redirect_valid = 1'b0;
        chk("redir_pop.empty", {31'd0, bus.out_valid}, 32'd0);
        tick("redir_pop");
        chk("redir_pop.pc", bus.out_pc, 32'h200);

        // Misaligned redirect: one fault entry, then halt
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        tick("mis");
        bus.redirect_valid = 1'b0;
        tick("mis");
        chk("mis.pc", bus.out_pc, 32'h102);
        chk("mis.inst", bus.out_inst, NOP_INST);
        chk("mis.fault", {31'd0, bus.out_fault}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick("halt");
            chk("halt.idle", {31'd0, bus.out_valid}, 32'd0);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        tick("resume");
        bus.redirect_valid = 1'b0;
        tick("resume");
        chk("resume.pc", bus.out_pc, 32'h300);
        chk("resume.fault", {31'd0, bus.out_fault}, 32'd0);

        // PC wrap, then reset with entries queued
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick("wrap");
        bus.redirect_valid = 1'b0;
        tick("wrap");
        chk("wrap.pc0", bus.out_pc, 32'hFFFF_FFFC);
        tick("wrap");
        chk("wrap.pc1", bus.out_pc, 32'h0);
        bus.out_ready = 1'b0;
        tick("wrap_fill");
        tick("wrap_fill");
        rst = 1'b1;
        tick("midrst");
        rst = 1'b0;
        chk("midrst.valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst.addr", bus.imem_addr, RPC);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 11) == 0);
            bus.redirect_pc    = $urandom();
            if ($urandom_range(0, 3) != 0) bus.redirect_pc[1:0] = 2'b00;
            rst = ($urandom_range(0, 59) == 0);
            tick("rand");
        end
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end for the RV32I core. Sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives the IMEM address. Captures the returned instruction with its PC into a small queue.
- Presents {pc, inst, fault} to decode over a valid/ready handshake.
- Handles control-flow redirects from execute, including queue flush and misaligned-target fault reporting.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- QUEUE_DEPTH, 2, number of fetch-queue entries; power of two, minimum 2.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to IMEM; equals the PC register.
- imem_inst  input  32  instruction word returned combinationally by IMEM for imem_addr.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_pc  input  32  new PC target; sampled only when redirect_valid=1.
- out_valid  output  1  queue head is valid.
- out_ready  input  1  decode accepts the head this cycle.
- out_pc  output  32  PC of the head entry.
- out_inst  output  32  instruction of the head entry.
- out_fault  output  1  head entry is an instruction-address-misaligned fault.

Behaviour:
- Reset: when rst=1 at a clock edge, pc<=RESET_PC, queue emptied, state<=RUN.
  - Outputs after reset: out_valid=0, out_pc=0, out_inst=0, out_fault=0, imem_addr=RESET_PC.
  - Reset asserted mid-operation discards all queued entries and any pending redirect.
- States: RUN, FAULT, HALT.
- RUN:
  - push = (count<QUEUE_DEPTH) || (out_valid && out_ready).
  - On push: enqueue {pc, imem_inst, 0} and pc<=pc+4. The PC wraps modulo 2^32 (0xFFFF_FFFC -> 0x0).
  - No push: pc holds, and imem_addr is stable.
- FAULT:
  - Entered from a redirect whose redirect_pc[1:0]!=0.
  - Enqueues exactly one entry {pc, 32'h0000_0013, 1} when push is allowed, then goes to HALT. pc is not incremented.
- HALT:
  - No enqueues. Already-queued entries continue to drain normally.
  - The state is left only by a redirect or by reset.
- Redirect (any state):
  - Takes priority over push and pop in the same cycle.
  - Next cycle: queue empty (out_valid=0) and pc=redirect_pc.
  - State becomes RUN if redirect_pc[1:0]==0, else FAULT.
  - A head accepted in the redirect cycle still counts as consumed by decode. Everything else in the queue is dropped.
- Pop: on out_valid && out_ready, the head advances. Order is strictly FIFO.
- Full with simultaneous pop: push and pop both occur; count is unchanged.
- Latency: the instruction at pc appears at the queue head 1 cycle after it is presented, provided the queue was empty.
- Throughput: 1 instruction/cycle sustained with out_ready=1.
- Output contract: out_* are driven from registered queue storage, not combinationally from imem_inst.
- Stability rule: while out_valid=1 and out_ready=0, out_pc/out_inst/out_fault must hold stable (absent a redirect).
- Count: width clog2(QUEUE_DEPTH)+1. Overflow and underflow are impossible by construction; assert this in simulation.

Decomposition:
- Package rv32i_pkg:
  - XLEN=32.
  - NOP_INST=32'h0000_0013.
  - typedef fetch_entry_t {pc, inst, fault}.
  - enum fetch_state_t {RUN, FAULT, HALT}.
- Sub-module fetch_queue:
  - Parameterised synchronous FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: head, valid, count.
  - flush has priority over push.
  - if_fetch_unit holds the PC, the FSM and the push/redirect logic.

Test Plan:
1. rst=1 for 2 cycles, then 0, out_ready=1 -> imem_addr sequence 0x0,0x4,0x8. out_valid rises 1 cycle after reset release with out_pc=0x0, then 0x4, 0x8 on consecutive cycles; out_fault=0.
2. Backpressure: out_ready=0 for 5 cycles from reset -> count saturates at 2 and imem_addr holds at 0x8. On out_ready=1, outputs are pc 0x0,0x4,0x8,0xC in order with no gaps and no loss; head stable while stalled.
3. Redirect while full: redirect_valid=1, redirect_pc=0x100 -> next cycle out_valid=0 and imem_addr=0x100; following cycle out_pc=0x100 with its instruction.
4. Simultaneous redirect (0x200) with pop on a full queue -> the popped head is consumed and the remaining entry is dropped. The next valid out_pc is 0x200.
5. Misaligned redirect 0x102 -> one entry out_pc=0x102, out_inst=0x0000_0013, out_fault=1. Then out_valid stays 0 for 10 cycles; redirect 0x300 resumes at 0x300 with fault=0.
6. PC wrap and mid-run reset: redirect 0xFFFF_FFFC -> out_pc 0xFFFF_FFFC then 0x0. Asserting rst with 2 queued entries -> next cycle out_valid=0 and imem_addr=RESET_PC.
